// File: rtl/seq_pkg.sv
// Shared constants and state encoding for the serial pattern generator.
package seq_pkg;

    localparam int CNT_W = 8;
    localparam logic [3:0] SEQ_1001 = 4'b1001;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SEND = 2'd1;
    localparam state_t ST_GAP  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/seq_piso.sv
// Parallel-in serial-out shift register: load wins over shift, shifts left, MSB is the serial bit.
module seq_piso
    import seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         msb
);

    logic [W-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

    assign msb = q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: repeats a latched PAT_W-bit pattern MSB-first with optional idle gaps,
// then pulses done. Outputs are decoded purely from state and the shift register.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] count,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(PAT_W);

    state_t           state;
    logic [PAT_W-1:0] pat;
    logic [CNT_W-1:0] reps;
    logic [BW-1:0]    bitcnt;
    logic [PAT_W-1:0] pat_d;
    logic             load;
    logic             shift;
    logic             last_bit;
    logic             gap_last;
    logic             msb;

    assign last_bit = (bitcnt == BW'(PAT_W - 1));
    assign pat_d    = (state == ST_IDLE) ? pat_in : pat;

    // Reload happens on acceptance, on back-to-back frames, and on the last gap cycle.
    always_comb begin
        load = 1'b0;
        case (state)
            ST_IDLE: load = start && !abort;
            ST_SEND: load = !abort && last_bit && (reps != CNT_W'(1)) && (GAP == 0);
            ST_GAP:  load = !abort && gap_last;
            default: load = 1'b0;
        endcase
        shift = (state == ST_SEND) && !load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pat    <= '0;
            reps   <= '0;
            bitcnt <= '0;
        end else if (abort) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pat    <= pat_in;
                        reps   <= count;
                        bitcnt <= '0;
                        state  <= (count != '0) ? ST_SEND : ST_DONE;
                    end
                end
                ST_SEND: begin
                    if (last_bit) begin
                        bitcnt <= '0;
                        if (reps != '0) begin
                            reps <= reps - 1'b1;
                        end
                        if (reps == CNT_W'(1)) begin
                            state <= ST_DONE;
                        end else if (GAP > 0) begin
                            state <= ST_GAP;
                        end
                    end else begin
                        bitcnt <= bitcnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_last) begin
                        state <= ST_SEND;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    generate
        if (GAP > 0) begin : g_gap
            localparam int GW = $clog2(GAP + 1);
            logic [GW-1:0] gapcnt;

            // Held at zero outside GAP so every gap starts counting from zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    gapcnt <= '0;
                end else if (state == ST_GAP && !abort && !gap_last) begin
                    gapcnt <= gapcnt + 1'b1;
                end else begin
                    gapcnt <= '0;
                end
            end

            assign gap_last = (gapcnt == GW'(GAP - 1));
        end else begin : g_nogap
            assign gap_last = 1'b1;
        end
    endgenerate

    seq_piso #(
        .W(PAT_W)
    ) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .d     (pat_d),
        .msb   (msb)
    );

    assign valid = (state == ST_SEND);
    assign out   = valid && msb;
    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed scoreboard bench for seq_pattern_gen: per-cycle expected {out,valid,busy,done} vectors.
module tb_seq_pattern_gen;
    import seq_pkg::*;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic       start2 = 1'b0;
    logic       abort  = 1'b0;
    logic [3:0] pat_in = '0;
    logic [7:0] count  = '0;

    logic out0, valid0, busy0, done0;
    logic out2, valid2, busy2, done2;

    seq_pattern_gen #(.PAT_W(4), .GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pat_in(pat_in),
        .count(count), .out(out0), .valid(valid0), .busy(busy0), .done(done0)
    );

    seq_pattern_gen #(.PAT_W(4), .GAP(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .pat_in(pat_in),
        .count(count), .out(out2), .valid(valid2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] sb[$];

    // Non-overlapping 1001 detector fed by dut0's serial output.
    logic       det_en = 1'b0;
    logic [2:0] hist;
    int         det_cnt;

    always @(posedge clk) begin
        if (!det_en) begin
            hist    <= '0;
            det_cnt <= 0;
        end else if ({hist, out0} == SEQ_1001) begin
            hist    <= '0;
            det_cnt <= det_cnt + 1;
        end else begin
            hist <= {hist[1:0], out0};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [3:0] p);
        for (int i = 3; i >= 0; i--) sb.push_back({p[i], 1'b1, 1'b1, 1'b0});
    endtask

    task automatic push_gap(input int n);
        for (int i = 0; i < n; i++) sb.push_back(4'b0010);
    endtask

    task automatic push_done();
        sb.push_back(4'b0011);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) sb.push_back(4'b0000);
    endtask

    // Accept at the next edge; returns #1 into cycle 1.
    task automatic go(input bit sel, input logic [3:0] p, input logic [7:0] c);
        pat_in = p;
        count  = c;
        if (sel) start2 = 1'b1;
        else     start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic drain(input string tag, input bit sel, input bit chaos);
        int         cyc;
        logic [3:0] exp;
        logic [3:0] obs;
        cyc = 0;
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            obs = sel ? {out2, valid2, busy2, done2} : {out0, valid0, busy0, done0};
            check($sformatf("%s_c%0d", tag, cyc), {28'd0, obs}, {28'd0, exp});
            if (chaos && exp[1]) begin
                start  = 1'($urandom_range(0, 1));
                pat_in = 4'($urandom);
                count  = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            cyc++;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        #1;
        check("reset_dut0", {28'd0, out0, valid0, busy0, done0}, 32'd0);
        check("reset_dut2", {28'd0, out2, valid2, busy2, done2}, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Start on the first edge after reset release.
        rst_n = 1'b1;
        go(0, 4'b1001, 8'd1);
        push_frame(4'b1001); push_done(); push_idle(2);
        drain("basic", 0, 0);

        go(1, 4'b1001, 8'd3);
        push_frame(4'b1001); push_gap(2); push_frame(4'b1001); push_gap(2);
        push_frame(4'b1001); push_done(); push_idle(2);
        drain("gap", 1, 0);

        go(0, 4'b1001, 8'd0);
        push_done(); push_idle(2);
        drain("zero", 0, 0);

        abort = 1'b1;
        go(0, 4'b1111, 8'd2);
        abort = 1'b0;
        push_idle(2);
        drain("abort_idle", 0, 0);

        go(0, 4'b1001, 8'd2);
        sb.push_back(4'b1110); sb.push_back(4'b0110);
        drain("abort_pre", 0, 0);
        abort = 1'b1;
        sb.push_back(4'b0110);
        drain("abort_b3", 0, 0);
        abort = 1'b0;
        push_idle(3);
        drain("abort_post", 0, 0);
        go(0, 4'b1100, 8'd1);
        push_frame(4'b1100); push_done(); push_idle(1);
        drain("after_abort", 0, 0);

        go(0, 4'b1001, 8'd2);
        push_frame(4'b1001); push_frame(4'b1001); push_done(); push_idle(2);
        drain("ignore", 0, 1);

        go(0, 4'b1001, 8'd3);
        sb.push_back(4'b1110); sb.push_back(4'b0110);
        drain("pre_rst", 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {28'd0, out0, valid0, busy0, done0}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_idle(2);
        drain("post_rst", 0, 0);

        det_en = 1'b1;
        go(0, SEQ_1001, 8'd4);
        for (int i = 0; i < 4; i++) push_frame(SEQ_1001);
        push_done(); push_idle(1);
        drain("loop", 0, 0);
        check("loop_detects", 32'(det_cnt), 32'd4);
        det_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
